// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: immediate-extension mode encoding and
// the occupancy states of the registered immediate stage.
package mips_defs;

    localparam int unsigned EXT_MODE_W = 3;

    localparam logic [EXT_MODE_W-1:0] EXT_SIGN   = 3'd0;
    localparam logic [EXT_MODE_W-1:0] EXT_ZERO   = 3'd1;
    localparam logic [EXT_MODE_W-1:0] EXT_LUI    = 3'd2;
    localparam logic [EXT_MODE_W-1:0] EXT_BRANCH = 3'd3;
    localparam logic [EXT_MODE_W-1:0] EXT_JUMP   = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/result bundle between decode, the immediate stage and execute.
interface imm_ext_pipe_if
    import mips_defs::*;
#(
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned OUT_W  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [JIDX_W-1:0]     in_field;
    logic [EXT_MODE_W-1:0] in_mode;
    logic [OUT_W-1:0]      in_pc4;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_err;

    // master: the surrounding pipeline (decode side drives requests, execute side drives out_ready)
    modport master (
        output in_valid, in_field, in_mode, in_pc4, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    // slave: the immediate stage itself
    modport slave (
        input  in_valid, in_field, in_mode, in_pc4, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, LUI, branch offset, jump target.
module imm_ext_core
    import mips_defs::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned OUT_W  = 32
) (
    input  logic [JIDX_W-1:0]     field,
    input  logic [EXT_MODE_W-1:0] mode,
    input  logic [OUT_W-1:0]      pc4,
    output logic [OUT_W-1:0]      data,
    output logic                  err
);
    logic [IN_W-1:0]  imm;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] jump_hi_mask;
    logic [OUT_W-1:0] jump_lo;

    assign imm          = field[IN_W-1:0];
    assign sign_ext     = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    // Shift/mask form keeps JUMP legal even when OUT_W == JIDX_W+2 (no pc4 bits kept).
    assign jump_hi_mask = {OUT_W{1'b1}} << (JIDX_W + 2);
    assign jump_lo      = {{(OUT_W-JIDX_W){1'b0}}, field} << 2;

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            EXT_SIGN:   data = sign_ext;
            EXT_ZERO:   data = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_LUI:    data = {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: data = {sign_ext[OUT_W-3:0], 2'b00};
            EXT_JUMP:   data = (pc4 & jump_hi_mask) | jump_lo;
            default:    err  = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-generation stage: extender followed by a 2-entry skid
// buffer with valid/ready handshake, synchronous reset and flush.
module imm_ext_pipe
    import mips_defs::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned JIDX_W = 26,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_ext_pipe_if.slave       bus
);
    if (OUT_W < JIDX_W + 2 || OUT_W < IN_W + 2 || JIDX_W < IN_W) begin : g_bad_width
        $error("imm_ext_pipe: need OUT_W >= JIDX_W+2, OUT_W >= IN_W+2, JIDX_W >= IN_W");
    end

    skid_state_e      state, next_state;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic [OUT_W-1:0] main_data, skid_data;
    logic             main_err, skid_err;
    logic             in_ready, out_valid, in_fire, out_fire;
    logic             load_main_in, load_main_skid, load_skid;

    imm_ext_core #(
        .IN_W   (IN_W),
        .JIDX_W (JIDX_W),
        .OUT_W  (OUT_W)
    ) u_core (
        .field (bus.in_field),
        .mode  (bus.in_mode),
        .pc4   (bus.in_pc4),
        .data  (ext_data),
        .err   (ext_err)
    );

    // Handshake flags depend only on the registered state.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    next_state   = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    next_state = ST_FULL;
                    load_skid  = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    next_state     = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_data <= ext_data;
                main_err  <= ext_err;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= ext_data;
                skid_err  <= ext_err;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data;
    assign bus.out_err   = main_err;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe.
module tb_imm_ext_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    imm_ext_pipe_if #(.JIDX_W(26), .OUT_W(32)) bus ();

    imm_ext_pipe #(
        .IN_W   (16),
        .JIDX_W (26),
        .OUT_W  (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] mode, input logic [25:0] field,
                         input logic [31:0] pc4);
        bus.in_valid = v;
        bus.in_mode  = mode;
        bus.in_field = field;
        bus.in_pc4   = pc4;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic e);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({tag, "_data"},  bus.out_data, d);
        check({tag, "_err"},   {31'd0, bus.out_err}, {31'd0, e});
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        expect_out("reset", 1'b0, 32'h0, 1'b0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single requests, drained every cycle
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd0, 26'h000FFF0, 32'd0);
        step();
        expect_out("sign", 1'b1, 32'hFFFFFFF0, 1'b0);
        drive(1'b1, 3'd1, 26'h000FFF0, 32'd0);
        step();
        expect_out("zero", 1'b1, 32'h0000FFF0, 1'b0);
        drive(1'b1, 3'd2, 26'h0001234, 32'd0);
        step();
        expect_out("lui", 1'b1, 32'h12340000, 1'b0);
        drive(1'b1, 3'd3, 26'h0008001, 32'd0);
        step();
        expect_out("branch", 1'b1, 32'hFFFE0004, 1'b0);
        drive(1'b1, 3'd4, 26'h0000100, 32'hA0000010);
        step();
        expect_out("jump", 1'b1, 32'hA0000400, 1'b0);
        drive(1'b1, 3'd6, 26'h0001234, 32'hFFFFFFFF);
        step();
        expect_out("illegal", 1'b1, 32'h0, 1'b1);
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        step();
        check("drained_valid", {31'd0, bus.out_valid}, 32'd0);

        // Back-pressure: A, B accepted, C stalled, then ordered drain
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 26'h0000001, 32'd0);
        step();
        check("bp_a_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp_a_data", bus.out_data, 32'h00000001);
        drive(1'b1, 3'd1, 26'h0000002, 32'd0);
        step();
        check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_b_hold_a", bus.out_data, 32'h00000001);
        drive(1'b1, 3'd2, 26'h0000003, 32'd0);
        step();
        check("bp_c_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        expect_out("bp_stall1", 1'b1, 32'h00000001, 1'b0);
        step();
        expect_out("bp_stall2", 1'b1, 32'h00000001, 1'b0);
        bus.out_ready = 1'b1;
        step();
        expect_out("bp_drain_b", 1'b1, 32'h00000002, 1'b0);
        check("bp_drain_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        expect_out("bp_drain_c", 1'b1, 32'h00030000, 1'b0);
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        step();
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Streaming 8 requests, one result per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd1, 26'h0000100 + 26'(i), 32'd0);
            check($sformatf("stream_ready%0d", i), {31'd0, bus.in_ready}, 32'd1);
            step();
            expect_out($sformatf("stream%0d", i), 1'b1, 32'h00000100 + 32'(i), 1'b0);
        end
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        step();
        check("stream_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush while FULL with a request presented
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 26'h0000005, 32'd0);
        step();
        drive(1'b1, 3'd1, 26'h0000006, 32'd0);
        step();
        check("fl_full_ready", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 3'd1, 26'h0000007, 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        expect_out("flush", 1'b0, 32'h0, 1'b0);
        check("flush_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("flush_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-stall
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd7, 26'h0000009, 32'd0);
        step();
        drive(1'b1, 3'd0, 26'h000000A, 32'd0);
        step();
        check("rst_full_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        expect_out("rst_mid", 1'b0, 32'h0, 1'b0);
        check("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);

        // rst and flush together with a request presented
        drive(1'b1, 3'd1, 26'h000000B, 32'd0);
        step();
        rst   = 1'b1;
        flush = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'd0, 26'd0, 32'd0);
        expect_out("rst_flush", 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-generation stage for the MIPS datapath. It sits between decode and execute and replaces the purely combinational sign/zero extender. Five extension modes are supported: sign, zero, LUI, branch offset and jump target. Results are buffered behind a valid/ready handshake with a 2-entry skid buffer and a synchronous flush.

Parameters:
IN_W, 16, immediate field width (instr[15:0])
JIDX_W, 26, jump instr_index width (instr[25:0])
OUT_W, 32, result width; constraints OUT_W >= JIDX_W+2 and OUT_W >= IN_W+2 (elaboration-time check)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush (branch mispredict/exception)
in_valid  in  1  upstream has a request
in_ready  out  1  stage can accept; decoded from registered state only
in_field  in  JIDX_W  instr[JIDX_W-1:0]; imm = in_field[IN_W-1:0]
in_mode  in  3  0 SIGN, 1 ZERO, 2 LUI, 3 BRANCH, 4 JUMP, 5-7 illegal
in_pc4  in  OUT_W  PC+4 of the instruction (used by JUMP)
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_data  out  OUT_W  extended value
out_err  out  1  request carried an illegal mode

Behaviour:
- Extension (combinational, applied before capture):
  - SIGN = {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - ZERO = {0, imm}
  - LUI = {imm, (OUT_W-IN_W) zeros}
  - BRANCH = SIGN << 2, truncated to OUT_W
  - JUMP = {in_pc4[OUT_W-1:JIDX_W+2], in_field, 2'b00}
  - illegal mode: data = 0, err = 1
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data/err are captured only on in_fire.
- States, encoded by entry count:
  - EMPTY: out_valid=0, in_ready=1
  - ONE: out_valid=1, skid empty, in_ready=1
  - FULL: out_valid=1, skid holds a second result, in_ready=0
- Transitions:
  - EMPTY: in_fire -> ONE (main reg loaded)
  - ONE: in_fire & !out_fire -> FULL (skid loaded); in_fire & out_fire -> ONE (main reg reloaded from input); !in_fire & out_fire -> EMPTY; otherwise hold
  - FULL: out_fire -> ONE (main <= skid); otherwise hold. No input is accepted in FULL.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 result per cycle when out_ready stays high.
- Ordering: strict FIFO. out_data/out_err stay stable while out_valid & !out_ready.
- in_ready has no combinational path from out_ready or in_valid.
- Reset (rst=1 at an edge): state EMPTY; out_valid=0, out_data=0, out_err=0, skid cleared; in_ready=1 from the next cycle. rst overrides everything, including mid-transfer.
- flush: same effect as reset but lower priority than rst. A request presented in the same cycle as flush is dropped, even if in_ready=1. Downstream must ignore out_fire in the flush cycle; the stage is empty afterwards.
- rst and flush together: reset semantics apply.

Decomposition:
- Shared package (mips_defs): mode encoding constants (EXT_SIGN..EXT_JUMP), EXT_MODE_W=3.
- Sub-module imm_ext_core: combinational extension, parametrised like the parent, with ports field/mode/pc4 -> data/err.
- imm_ext_pipe instantiates imm_ext_core and holds the skid state machine.

Test Plan:
1. Reset, then a SIGN request with imm=16'hFFF0, out_ready=1 -> the next cycle shows out_valid=1, out_data=32'hFFFFFFF0, out_err=0. The same imm in ZERO mode -> 32'h0000FFF0.
2. LUI with imm=16'h1234 -> 32'h12340000. BRANCH with imm=16'h8001 -> 32'hFFFE0004.
3. JUMP with in_pc4=32'hA0000010 and in_field=26'h0000100 -> 32'hA0000400. Mode 6 -> out_data=0, out_err=1.
4. Hold out_ready=0 and send 3 back-to-back requests (A, B, C):
   - A and B are accepted; in_ready=0 after the second accept; C is stalled.
   - Then raise out_ready: results drain as A, B, C in order, with out_data stable during the stall.
5. Streaming 8 requests with out_ready=1 -> 8 results on 8 consecutive cycles, in_ready never drops.
6. In FULL state, assert flush for one cycle while in_valid=1 -> the next cycle shows out_valid=0, in_ready=1, and the flushed request never appears. Repeat with rst asserted mid-stall -> all outputs 0.
